// File: rtl/fb_port_arbiter.sv
// ============================================================================
// fb_port_arbiter : framebuffer RAM port arbiter, scanout vs game logic
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fb_port_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 3,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_miss,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [DATA_W-1:0] gl_wdata,
    output logic              gl_gnt,
    output logic              gl_rvalid,
    output logic [DATA_W-1:0] gl_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       miss_count
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] c_limit = WAIT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_VGA = 2'd1,
        SERVE_GL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WAIT_W-1:0]  r_wait;
    logic [WAIT_W-1:0]  w_wait_next;
    logic               w_gl_eligible;
    logic               w_force;
    logic               w_miss;

    logic               r_gl_gnt;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_wdata;
    logic               r_vga_miss;
    logic [15:0]        r_miss_count;
    logic               r_vga_rd;
    logic               r_gl_rd;

    // State names the owner of the RAM command presented this cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = IDLE;
        w_miss        = 1'b0;
        w_wait_next   = r_wait;
        // A request still held in the cycle its grant is visible is the old one.
        w_gl_eligible = gl_req && !r_gl_gnt;
        w_force       = w_gl_eligible && (r_wait >= c_limit);

        if (w_force) begin
            w_state_next = SERVE_GL;
            w_miss       = vga_req;
        end else if (vga_req) begin
            w_state_next = SERVE_VGA;
        end else if (w_gl_eligible) begin
            w_state_next = SERVE_GL;
        end

        if (!w_gl_eligible || (w_state_next == SERVE_GL)) begin
            w_wait_next = '0;
        end else if (r_wait < c_limit) begin
            w_wait_next = r_wait + WAIT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait       <= '0;
            r_gl_gnt     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_vga_miss   <= 1'b0;
            r_miss_count <= '0;
            r_vga_rd     <= 1'b0;
            r_gl_rd      <= 1'b0;
        end else begin
            r_wait     <= w_wait_next;
            r_gl_gnt   <= (w_state_next == SERVE_GL);
            r_ram_we   <= (w_state_next == SERVE_GL) && gl_we;
            r_vga_miss <= w_miss;

            if (w_state_next == SERVE_VGA) begin
                r_ram_addr <= vga_addr;
            end else if (w_state_next == SERVE_GL) begin
                r_ram_addr  <= gl_addr;
                r_ram_wdata <= gl_wdata;
            end

            if (w_miss && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'd1;
            end

            // Read data returns one cycle after the command; flag its owner.
            r_vga_rd <= (r_state == SERVE_VGA);
            r_gl_rd  <= (r_state == SERVE_GL) && !r_ram_we;
        end
    end

    assign gl_gnt     = r_gl_gnt;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign vga_miss   = r_vga_miss;
    assign miss_count = r_miss_count;
    assign vga_valid  = r_vga_rd;
    assign vga_data   = ram_rdata;
    assign gl_rvalid  = r_gl_rd;
    assign gl_rdata   = ram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
// ============================================================================
// tb_fb_port_arbiter : directed + randomized bench against a reference model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_fb_port_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 3;
    localparam int STARVE = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              vga_req = 1'b0;
    logic [ADDR_W-1:0] vga_addr = '0;
    logic              vga_valid;
    logic [DATA_W-1:0] vga_data;
    logic              vga_miss;
    logic              gl_req = 1'b0;
    logic              gl_we = 1'b0;
    logic [ADDR_W-1:0] gl_addr = '0;
    logic [DATA_W-1:0] gl_wdata = '0;
    logic              gl_gnt;
    logic              gl_rvalid;
    logic [DATA_W-1:0] gl_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [15:0]       miss_count;

    fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE)) dut (
        .clock(clock), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid),
        .vga_data(vga_data), .vga_miss(vga_miss),
        .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
        .gl_gnt(gl_gnt), .gl_rvalid(gl_rvalid), .gl_rdata(gl_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    // Single-port RAM, one-cycle read latency.
    logic [DATA_W-1:0] ram [0:1023];
    always @(posedge clock) begin
        if (ram_we) ram[ram_addr[9:0]] <= ram_wdata;
        ram_rdata <= ram[ram_addr[9:0]];
    end

    typedef struct {
        bit                gnt, we, miss, vrd, grd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata, rdata;
    } exp_t;

    int unsigned       n_tests = 0;
    int unsigned       n_fail  = 0;
    logic [DATA_W-1:0] m_mem [0:1023];
    int                m_wait;
    bit                m_gnt_prev;
    logic [15:0]       m_misses;
    logic [ADDR_W-1:0] m_addr;
    exp_t              prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait     = 0;
        m_gnt_prev = 0;
        m_misses   = '0;
        m_addr     = '0;
        prev       = '{default: '0};
    endtask

    // One cycle: drive, predict, advance an edge, compare at the falling edge.
    task automatic do_cycle(input bit vr, input logic [ADDR_W-1:0] va, input bit gr,
                            input bit gw, input logic [ADDR_W-1:0] ga,
                            input logic [DATA_W-1:0] gd, output bit granted);
        exp_t e;
        bit   gl_ok, forced;
        vga_req = vr; vga_addr = va;
        gl_req = gr; gl_we = gw; gl_addr = ga; gl_wdata = gd;

        e      = '{default: '0};
        e.addr = m_addr;
        gl_ok  = gr && !m_gnt_prev;
        forced = gl_ok && (m_wait >= STARVE);
        if (forced || (!vr && gl_ok)) begin
            e.gnt = 1; e.addr = ga; e.we = gw; e.grd = !gw;
            e.rdata = m_mem[ga[9:0]];
            if (gw) begin
                e.wdata = gd;
                m_mem[ga[9:0]] = gd;
            end
        end else if (vr) begin
            e.vrd = 1; e.addr = va;
            e.rdata = m_mem[va[9:0]];
        end
        e.miss = forced && vr;
        if (e.miss && m_misses != 16'hFFFF) m_misses++;
        m_wait     = (gr && !m_gnt_prev && !e.gnt) ? m_wait + 1 : 0;
        m_gnt_prev = e.gnt;
        m_addr     = e.addr;

        @(posedge clock);
        @(negedge clock);
        check("gl_gnt", gl_gnt, e.gnt);
        check("ram_we", ram_we, e.we);
        check("vga_miss", vga_miss, e.miss);
        check("miss_count", miss_count, m_misses);
        check("ram_addr", ram_addr, e.addr);
        if (e.we) check("ram_wdata", ram_wdata, e.wdata);
        check("vga_valid", vga_valid, prev.vrd);
        if (prev.vrd) check("vga_data", vga_data, prev.rdata);
        check("gl_rvalid", gl_rvalid, prev.grd);
        if (prev.grd) check("gl_rdata", gl_rdata, prev.rdata);
        prev    = e;
        granted = e.gnt;
    endtask

    task automatic idle_cycle();
        bit g;
        do_cycle(0, '0, 0, 0, '0, '0, g);
    endtask

    // Holds a game-logic request until granted; returns cycles taken.
    task automatic gl_op(input bit gw, input logic [ADDR_W-1:0] ga,
                         input logic [DATA_W-1:0] gd, input bit vga_busy,
                         output int cycles);
        bit g;
        g = 0;
        cycles = 0;
        while (!g && cycles < 32) begin
            do_cycle(vga_busy, ADDR_W'(cycles), 1, gw, ga, gd, g);
            cycles++;
        end
        if (!g) check("gl_grant_timeout", 0, 1);
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        vga_req = 0; gl_req = 0;
        #1;
        check("rst_gl_gnt", gl_gnt, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_vga_valid", vga_valid, 0);
        check("rst_gl_rvalid", gl_rvalid, 0);
        check("rst_vga_miss", vga_miss, 0);
        check("rst_miss_count", miss_count, 0);
        @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        model_reset();
        @(negedge clock);
    endtask

    initial begin
        int n;
        bit g;
        bit g_active, g_extra, g_we;
        logic [ADDR_W-1:0] g_addr;
        logic [DATA_W-1:0] g_data;
        int pct;

        for (int i = 0; i < 1024; i++) begin
            ram[i]   = DATA_W'($urandom);
            m_mem[i] = ram[i];
        end
        ram[100] = 3'b111; m_mem[100] = 3'b111;
        @(negedge clock);
        apply_reset();

        // Single scanout read.
        do_cycle(1, ADDR_W'(100), 0, 0, '0, '0, g);
        check("rd100_addr", ram_addr, 100);
        idle_cycle();
        check("rd100_valid", vga_valid, 1);
        check("rd100_data", vga_data, 3'b111);

        // Game-logic write then readback.
        gl_op(1, ADDR_W'(645), 3'b100, 0, n);
        check("wr645_latency", n, 1);
        idle_cycle();
        gl_op(0, ADDR_W'(645), 3'b000, 0, n);
        idle_cycle();
        check("rd645_rvalid", gl_rvalid, 1);
        check("rd645_data", gl_rdata, 3'b100);

        // Starvation: scanout every cycle, forced grant after the limit.
        gl_op(1, ADDR_W'(700), 3'b101, 1, n);
        check("starve_cycles", n, STARVE + 1);
        do_cycle(1, ADDR_W'(7), 1, 1, ADDR_W'(700), 3'b101, g);
        check("held_no_regrant", g, 0);
        idle_cycle();
        idle_cycle();
        check("starve_miss_total", miss_count, 1);

        // Reset while a read is in flight.
        do_cycle(1, ADDR_W'(5), 0, 0, '0, '0, g);
        apply_reset();
        idle_cycle();
        check("post_rst_vga_valid", vga_valid, 0);
        check("post_rst_gl_rvalid", gl_rvalid, 0);

        // Randomized traffic with varying scanout density.
        g_active = 0; g_extra = 0; g_we = 0; g_addr = '0; g_data = '0; pct = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: pct = 0;
                    1: pct = 30;
                    2: pct = 70;
                    default: pct = 100;
                endcase
            end
            if (!g_active && !g_extra && $urandom_range(0, 2) == 0) begin
                g_active = 1;
                g_we     = $urandom_range(0, 1) == 1;
                g_addr   = ADDR_W'($urandom_range(0, 63));
                g_data   = DATA_W'($urandom);
            end
            do_cycle($urandom_range(0, 99) < pct, ADDR_W'($urandom_range(0, 63)),
                     g_active || g_extra, g_we, g_addr, g_data, g);
            if (g_extra) begin
                g_extra = 0;
            end else if (g_active && g) begin
                g_active = 0;
                g_extra  = $urandom_range(0, 1) == 1;
            end
        end
        idle_cycle();
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
